// File: rtl/seg7_scan.sv
`timescale 1ns/1ps
// seg7_scan: multiplexed driver for a multi-digit 7-segment display.
// Latches a frame-coherent snapshot of all digit values, scans one digit per
// refresh slot with guard blanking, and applies leading-zero blanking,
// decimal points and output polarity.
module seg7_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int LZB_EN         = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       val,
    input  logic [NUM_DIGITS-1:0]         dp,
    input  logic [NUM_DIGITS-1:0]         blank,
    output logic [6:0]                    seg,
    output logic                          seg_dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      GUARD_L  = CNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                     : {NUM_DIGITS{1'b0}};
    localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);

    // Scan state
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    tick;

    // Frame snapshot
    logic [4*NUM_DIGITS-1:0] snap_val_q, snap_val_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;

    // Output registers
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    seg_dp_q, seg_dp_d;
    logic [IDX_W-1:0]        digit_idx_q;

    // Combinational helpers
    logic [NUM_DIGITS-1:0]   lz;
    logic                    zero_chain;
    logic [3:0]              cur_val;
    logic                    cur_blank;
    logic                    cur_dp;
    logic                    guard;
    logic [6:0]              raw_seg;
    logic [NUM_DIGITS-1:0]   sel;

    // Prescaler, digit index and snapshot next-state
    always_comb begin
        tick         = en && (cnt_q == CNT_LAST);
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap_val_d   = snap_val_q;
        snap_dp_d    = snap_dp_q;
        snap_blank_d = snap_blank_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (en && (idx_q == '0) && (cnt_q == '0)) begin
            snap_val_d   = val;
            snap_dp_d    = dp;
            snap_blank_d = blank;
        end
    end

    // Leading-zero chain, walked from the most significant digit down
    always_comb begin
        lz         = '0;
        zero_chain = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            zero_chain = zero_chain && (snap_val_q[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
            lz[NUM_DIGITS-1-i] = (LZB_EN != 0) && (i != NUM_DIGITS - 1) && zero_chain;
        end
    end

    // Digit select, hex decode and polarity for the output register
    always_comb begin
        cur_val   = snap_val_q[{idx_q, 2'b00} +: 4];
        cur_blank = snap_blank_q[idx_q];
        cur_dp    = snap_dp_q[idx_q];
        guard     = (GUARD_CYCLES > 0) && (cnt_q < GUARD_L);

        case (cur_val)
            4'h0:    raw_seg = 7'b1111110;
            4'h1:    raw_seg = 7'b0110000;
            4'h2:    raw_seg = 7'b1101101;
            4'h3:    raw_seg = 7'b1111001;
            4'h4:    raw_seg = 7'b0110011;
            4'h5:    raw_seg = 7'b1011011;
            4'h6:    raw_seg = 7'b1011111;
            4'h7:    raw_seg = 7'b1110000;
            4'h8:    raw_seg = 7'b1111111;
            4'h9:    raw_seg = 7'b1110011;
            4'hA:    raw_seg = 7'b1110111;
            4'hB:    raw_seg = 7'b0011111;
            4'hC:    raw_seg = 7'b1001110;
            4'hD:    raw_seg = 7'b0111101;
            4'hE:    raw_seg = 7'b1001111;
            default: raw_seg = 7'b1000111;
        endcase

        sel        = '0;
        sel[idx_q] = 1'b1;

        if (!en || guard) begin
            an_d = AN_OFF;
        end else begin
            an_d = (AN_ACTIVE_LOW != 0) ? ~sel : sel;
        end

        if (cur_blank || lz[idx_q]) begin
            seg_d = SEG_OFF;
        end else begin
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~raw_seg : raw_seg;
        end

        seg_dp_d = (cur_dp && !cur_blank) ? ~DP_OFF : DP_OFF;
    end

    // State, snapshot and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_val_q   <= '0;
            snap_dp_q    <= '0;
            snap_blank_q <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            seg_dp_q     <= DP_OFF;
            digit_idx_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_val_q   <= snap_val_d;
            snap_dp_q    <= snap_dp_d;
            snap_blank_q <= snap_blank_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            seg_dp_q     <= seg_dp_d;
            digit_idx_q  <= idx_q;
        end
    end

    assign seg       = seg_q;
    assign seg_dp    = seg_dp_q;
    assign an        = an_q;
    assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_seg7_scan.sv
`timescale 1ns/1ps
// Directed bench for seg7_scan: 4 digits, 8-cycle slots, 2 guard cycles,
// active-low anodes, active-high segments, leading-zero blanking on.
module tb_seg7_scan;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    int checks;
    int failures;

    seg7_scan #(
        .NUM_DIGITS    (4),
        .REFRESH_DIV   (8),
        .GUARD_CYCLES  (2),
        .SEG_ACTIVE_LOW(0),
        .AN_ACTIVE_LOW (1),
        .LZB_EN        (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .val      (val),
        .dp       (dp),
        .blank    (blank),
        .seg      (seg),
        .seg_dp   (seg_dp),
        .an       (an),
        .digit_idx(digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        #12;
        checks++;
        if (an !== 4'b1111) begin
            failures++; $display("FAIL reset_an got=%b exp=1111", an);
        end
        checks++;
        if (seg !== 7'b0000000 || seg_dp !== 1'b0) begin
            failures++; $display("FAIL reset_seg got=%b/%b exp=0000000/0", seg, seg_dp);
        end
        checks++;
        if (digit_idx !== 2'd0) begin
            failures++; $display("FAIL reset_idx got=%0d exp=0", digit_idx);
        end
    endtask

    // One frame from reset release showing 1234
    task automatic test_scan;
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        int slot, c;
        exp_seg = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
        @(negedge clk);
        val = 16'h1234; dp = '0; blank = '0;
        rst = 1'b0; en = 1'b1;
        for (int f = 0; f < 32; f++) begin
            @(posedge clk); @(negedge clk);
            slot = f / 8; c = f % 8;
            exp_an = 4'b1111;
            if (c >= 2) exp_an[slot] = 1'b0;
            checks++;
            if (an !== exp_an) begin
                failures++; $display("FAIL scan_an f=%0d got=%b exp=%b", f, an, exp_an);
            end
            checks++;
            if (digit_idx !== 2'(slot)) begin
                failures++; $display("FAIL scan_idx f=%0d got=%0d exp=%0d", f, digit_idx, slot);
            end
            if (c >= 2) begin
                checks++;
                if (seg !== exp_seg[slot]) begin
                    failures++; $display("FAIL scan_seg f=%0d got=%b exp=%b", f, seg, exp_seg[slot]);
                end
            end
        end
    endtask

    // 0050 then 0000: blanking of high zeros, digit 0 always lit
    task automatic test_lzb;
        logic [6:0] exp_seg [8];
        int slot, c;
        exp_seg = '{7'b1111110, 7'b1011011, 7'b0000000, 7'b0000000,
                    7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000};
        val = 16'h0050;
        for (int f = 0; f < 64; f++) begin
            @(posedge clk); @(negedge clk);
            if (f == 31) val = 16'h0000;
            slot = f / 8; c = f % 8;
            if (c >= 2) begin
                checks++;
                if (seg !== exp_seg[slot]) begin
                    failures++; $display("FAIL lzb_seg f=%0d got=%b exp=%b", f, seg, exp_seg[slot]);
                end
            end
        end
    endtask

    // val changes while digit 2 is shown; frame keeps the old snapshot
    task automatic test_snapshot;
        logic [6:0] exp_seg;
        int c;
        val = 16'h1111;
        for (int f = 0; f < 64; f++) begin
            @(posedge clk); @(negedge clk);
            c = f % 8;
            exp_seg = (f < 32) ? 7'b0110000 : 7'b1101101;
            if (c >= 2) begin
                checks++;
                if (seg !== exp_seg) begin
                    failures++; $display("FAIL snap_seg f=%0d got=%b exp=%b", f, seg, exp_seg);
                end
            end
            if (f == 16) val = 16'h2222;
        end
    endtask

    // Force blank on digit 2, decimal points on digits 0 and 2
    task automatic test_blank_dp;
        logic [6:0] exp_seg [4];
        logic       exp_dp  [4];
        int slot, c;
        exp_seg = '{7'b1111111, 7'b1111111, 7'b0000000, 7'b1111111};
        exp_dp  = '{1'b1, 1'b0, 1'b0, 1'b0};
        val = 16'h8888; blank = 4'b0100; dp = 4'b0101;
        for (int f = 0; f < 32; f++) begin
            @(posedge clk); @(negedge clk);
            slot = f / 8; c = f % 8;
            if (c >= 2) begin
                checks++;
                if (seg !== exp_seg[slot] || seg_dp !== exp_dp[slot]) begin
                    failures++;
                    $display("FAIL bdp_seg f=%0d got=%b/%b exp=%b/%b",
                             f, seg, seg_dp, exp_seg[slot], exp_dp[slot]);
                end
            end
        end
        blank = '0; dp = '0;
    endtask

    // en low for 5 cycles in the middle of digit 1's slot
    task automatic test_enable;
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        int v, slot, c;
        exp_seg = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
        val = 16'h1234;
        for (int e = 0; e < 37; e++) begin
            @(posedge clk); @(negedge clk);
            if (e >= 12 && e <= 16) begin
                checks++;
                if (an !== 4'b1111 || digit_idx !== 2'd1) begin
                    failures++; $display("FAIL en_hold e=%0d got=%b/%0d exp=1111/1", e, an, digit_idx);
                end
            end else begin
                v = (e < 12) ? e : e - 5;
                slot = v / 8; c = v % 8;
                exp_an = 4'b1111;
                if (c >= 2) exp_an[slot] = 1'b0;
                checks++;
                if (an !== exp_an || digit_idx !== 2'(slot)) begin
                    failures++;
                    $display("FAIL en_scan e=%0d got=%b/%0d exp=%b/%0d", e, an, digit_idx, exp_an, slot);
                end
                if (c >= 2) begin
                    checks++;
                    if (seg !== exp_seg[slot]) begin
                        failures++; $display("FAIL en_seg e=%0d got=%b exp=%b", e, seg, exp_seg[slot]);
                    end
                end
            end
            if (e == 11) en = 1'b0;
            if (e == 16) en = 1'b1;
        end
    endtask

    // rst asserted between edges while digit 3 is driven
    task automatic test_async_reset;
        for (int f = 0; f < 28; f++) begin
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (an !== 4'b0111) begin
            failures++; $display("FAIL ar_pre got=%b exp=0111", an);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'b1111 || seg !== 7'b0000000 || digit_idx !== 2'd0) begin
            failures++;
            $display("FAIL ar_async got=%b/%b/%0d exp=1111/0000000/0", an, seg, digit_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int f = 0; f < 3; f++) begin
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (an !== 4'b1110 || seg !== 7'b0110011) begin
            failures++; $display("FAIL ar_restart got=%b/%b exp=1110/0110011", an, seg);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; en = 1'b0; val = '0; dp = '0; blank = '0;
        test_reset();
        test_scan();
        test_lzb();
        test_snapshot();
        test_blank_dp();
        test_enable();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
